// File: rtl/mips_store_buffer_pkg.sv
// Shared types for the MIPS posted-write store buffer.
// The SB_LOAD_FWD_EN macro, when defined, enables store-to-load forwarding.
package mips_store_buffer_pkg;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_WRITE = 2'd1,
      SB_READ  = 2'd2
   } sb_state_t;

   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mips_store_buffer_sb_fifo.sv
// Circular store queue: head/tail/count with push and pop.
// With SB_LOAD_FWD_EN defined it also returns the youngest entry whose word address matches.
module sb_fifo
   import mips_store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int PTR_W = sb_ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty
`ifdef SB_LOAD_FWD_EN
   ,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
`endif
);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [PTR_W:0]    count_reg;
   logic              push_ok, pop_ok;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push_ok) tail_reg <= tail_reg + 1'b1;
         if (pop_ok)  head_reg <= head_reg + 1'b1;
         if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
         else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
      end
   end

   // Storage carries no reset; validity is defined purely by head/count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem[tail_reg] <= push_addr;
         data_mem[tail_reg] <= push_data;
      end
   end

   assign head_addr = addr_mem[head_reg];
   assign head_data = data_mem[head_reg];

`ifdef SB_LOAD_FWD_EN
   logic [DEPTH-1:0] match;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [PTR_W-1:0] age;
         assign age       = PTR_W'(gi) - head_reg;
         assign match[gi] = ({1'b0, age} < count_reg) &&
                            (((addr_mem[gi] ^ lookup_addr) & ~ADDR_W'(3)) == '0);
      end
   endgenerate

   // Walk from oldest to youngest so the last match wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_reg + PTR_W'(k);
         if (match[idx]) begin
            hit      = 1'b1;
            hit_data = data_mem[idx];
         end
      end
   end
`endif

endmodule

// File: rtl/mips_store_buffer.sv
// Posted-write store buffer between the MEM stage and a single-outstanding memory port.
// Define SB_LOAD_FWD_EN to forward loads from queued stores and let misses bypass the queue.
module mips_store_buffer
   import mips_store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_ren,
   input  logic              core_wen,
   input  logic              core_sync,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_dout,
   output logic [DATA_W-1:0] core_din,
   output logic              core_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dout,
   input  logic [DATA_W-1:0] mem_din,
   input  logic              mem_ack,
   output logic              buf_empty
);

   localparam int PTR_W = sb_ptr_w(DEPTH);

   sb_state_t         state_reg, state_next;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_dout_reg;
   logic              mem_we_reg;

   logic              load_req, store_req, sync_req, load_issue;
   logic              push, pop, fifo_full, fifo_empty;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [PTR_W:0]    count;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   // Core requests are masked while reset is held; a simultaneous load+store keeps only the store.
   assign load_req  = core_ren && !core_wen && !rst;
   assign store_req = core_wen && !rst;
   assign sync_req  = core_sync && !rst;

   sb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (core_addr),
      .push_data  (core_dout),
      .pop        (pop),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (count),
      .full       (fifo_full),
      .empty      (fifo_empty)
`ifdef SB_LOAD_FWD_EN
      ,
      .lookup_addr(core_addr),
      .hit        (fwd_hit),
      .hit_data   (fwd_data)
`endif
   );

`ifdef SB_LOAD_FWD_EN
   // A miss cannot alias any queued store, so it may overtake them.
   assign load_issue = load_req && !fwd_hit && (state_reg == SB_IDLE);
`else
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
   assign load_issue = load_req && (state_reg == SB_IDLE) && (count == '0);
`endif

   assign buf_empty = fifo_empty;
   assign mem_req   = (state_reg != SB_IDLE);
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_dout  = mem_dout_reg;

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      push       = store_req && !fifo_full;
      core_stall = 1'b0;
      core_din   = '0;
      case (state_reg)
         SB_IDLE: begin
            if (load_issue)       state_next = SB_READ;
            else if (count != '0) state_next = SB_WRITE;
         end
         SB_WRITE: begin
            if (mem_ack) begin
               pop        = 1'b1;
               state_next = SB_IDLE;
            end
         end
         SB_READ: begin
            if (mem_ack) state_next = SB_IDLE;
         end
         default: state_next = SB_IDLE;
      endcase

      // Full uses the registered count, so a same-cycle pop does not free the slot yet.
      if (store_req && fifo_full) core_stall = 1'b1;
      if (load_req) begin
         if (fwd_hit)                                 core_din = fwd_data;
         else if (state_reg == SB_READ && mem_ack)    core_din = mem_din;
         else                                         core_stall = 1'b1;
      end
      if (sync_req && !fifo_empty) core_stall = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= SB_IDLE;
         mem_addr_reg <= '0;
         mem_dout_reg <= '0;
         mem_we_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == SB_IDLE) begin
            if (state_next == SB_READ) begin
               mem_addr_reg <= core_addr;
               mem_we_reg   <= 1'b0;
            end else if (state_next == SB_WRITE) begin
               mem_addr_reg <= head_addr;
               mem_dout_reg <= head_data;
               mem_we_reg   <= 1'b1;
            end
         end else if (mem_ack) begin
            mem_we_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mips_store_buffer.sv
`timescale 1ns/1ps
module tb_mips_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_ren, core_wen, core_sync;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_dout;
    logic [DW-1:0] core_din;
    logic          core_stall;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] mem_din;
    logic          mem_ack;
    logic          buf_empty;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd_cycles = 0;
    int n_wr_acks   = 0;

    mips_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .core_ren  (core_ren),
        .core_wen  (core_wen),
        .core_sync (core_sync),
        .core_addr (core_addr),
        .core_dout (core_dout),
        .core_din  (core_din),
        .core_stall(core_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_ack   (mem_ack),
        .buf_empty (buf_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && !mem_we) n_rd_cycles++;
        if (mem_req && mem_we && mem_ack) n_wr_acks++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!mem_req && k < 50) begin
            tick();
            k++;
        end
        chk(tag, mem_req, 1'b1);
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_wen  = 1'b1;
        core_addr = a;
        core_dout = d;
        #1;
        chk("store_no_stall", core_stall, 1'b0);
        $display("[TB] store addr=0x%0h data=0x%0h", a, d);
        tick();
        core_wen = 1'b0;
    endtask

    task automatic serve_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
        wait_req("wr_req");
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, a);
        chk("wr_data", mem_dout, d);
        repeat (lat) tick();
        mem_ack = 1'b1;
        $display("[TB] mem write addr=0x%0h data=0x%0h", mem_addr, mem_dout);
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        core_ren = 1'b0; core_wen = 1'b1; core_sync = 1'b1;
        core_addr = 32'h4; core_dout = 32'hDEAD;
        mem_din = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_req",   mem_req,    1'b0);
        chk("rst_we",    mem_we,     1'b0);
        chk("rst_addr",  mem_addr,   32'h0);
        chk("rst_dout",  mem_dout,   32'h0);
        chk("rst_din",   core_din,   32'h0);
        chk("rst_stall", core_stall, 1'b0);
        chk("rst_empty", buf_empty,  1'b1);
        core_wen = 1'b0; core_sync = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_empty", buf_empty, 1'b1);

        store(32'h10, 32'hA);
        store(32'h14, 32'hB);
        store(32'h18, 32'hC);
        serve_write(32'h10, 32'hA, 2);
        serve_write(32'h14, 32'hB, 2);
        #1;
        chk("t1_not_empty", buf_empty, 1'b0);
        serve_write(32'h18, 32'hC, 2);
        #1;
        chk("t1_empty", buf_empty, 1'b1);

        for (int i = 0; i <= DEPTH; i++) begin
            core_wen  = 1'b1;
            core_addr = 32'h100 + 32'(4 * i);
            core_dout = 32'(i + 1);
            #1;
            n_tests++;
            if (core_stall !== (i == DEPTH)) begin
                n_fail++;
                $error("FAIL t2_stall: i=%0d observed %0b", i, core_stall);
            end
            $display("[TB] store addr=0x%0h data=0x%0h stall=%0b", core_addr, core_dout, core_stall);
            if (i < DEPTH) tick();
        end
        tick();
        chk("t2_stall_held", core_stall, 1'b1);
        chk("t2_head_addr", mem_addr, 32'h100);
        mem_ack = 1'b1;
        #1;
        chk("t2_stall_on_pop", core_stall, 1'b1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t2_accept_after_ack", core_stall, 1'b0);
        tick();
        core_wen = 1'b0;
        for (int i = 1; i <= DEPTH; i++)
            serve_write(32'h100 + 32'(4 * i), 32'(i + 1), 0);
        #1;
        chk("t2_empty", buf_empty, 1'b1);

        store(32'h1C, 32'h77);
        core_sync = 1'b1;
        #1;
        chk("sync_stall", core_stall, 1'b1);
        serve_write(32'h1C, 32'h77, 1);
        #1;
        chk("sync_release", core_stall, 1'b0);
        core_sync = 1'b0;

`ifndef SB_LOAD_FWD_EN
        store(32'h20, 32'h55);
        core_ren  = 1'b1;
        core_addr = 32'h20;
        #1;
        chk("t3_stall_idle", core_stall, 1'b1);
        chk("t3_no_req", mem_req, 1'b0);
        tick();
        chk("t3_write_req", mem_req, 1'b1);
        chk("t3_write_we", mem_we, 1'b1);
        mem_ack = 1'b1;
        #1;
        chk("t3_stall_wr_ack", core_stall, 1'b1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t3_idle_gap", mem_req, 1'b0);
        chk("t3_stall_gap", core_stall, 1'b1);
        tick();
        chk("t3_read_req", mem_req, 1'b1);
        chk("t3_read_we", mem_we, 1'b0);
        chk("t3_read_addr", mem_addr, 32'h20);
        chk("t3_stall_read", core_stall, 1'b1);
        mem_ack = 1'b1;
        mem_din = 32'h55;
        #1;
        chk("t3_din", core_din, 32'h55);
        chk("t3_stall_drop", core_stall, 1'b0);
        $display("[TB] load addr=0x20 data=0x%0h", core_din);
        tick();
        mem_ack = 1'b0; core_ren = 1'b0; mem_din = '0;
        #1;
        chk("t3_idle_after", mem_req, 1'b0);
`else
        begin
            int rd_base;
            int wr_base;
            store(32'h30, 32'h1);
            store(32'h30, 32'h2);
            rd_base   = n_rd_cycles;
            core_ren  = 1'b1;
            core_addr = 32'h30;
            #1;
            chk("t4_din", core_din, 32'h2);
            chk("t4_stall", core_stall, 1'b0);
            $display("[TB] load addr=0x30 data=0x%0h (forwarded)", core_din);
            tick();
            core_ren = 1'b0;
            chk("t4_we_busy", mem_we, 1'b1);
            serve_write(32'h30, 32'h1, 1);
            serve_write(32'h30, 32'h2, 1);
            chk("t4_no_read", n_rd_cycles, rd_base);

            store(32'h50, 32'h7);
            store(32'h54, 32'h8);
            wr_base   = n_wr_acks;
            core_ren  = 1'b1;
            core_addr = 32'h40;
            #1;
            chk("t5_stall", core_stall, 1'b1);
            chk("t5_inflight", mem_addr, 32'h50);
            mem_ack = 1'b1;
            #1;
            chk("t5_stall_ack", core_stall, 1'b1);
            tick();
            mem_ack = 1'b0;
            #1;
            chk("t5_gap", mem_req, 1'b0);
            tick();
            chk("t5_read_we", mem_we, 1'b0);
            chk("t5_read_addr", mem_addr, 32'h40);
            chk("t5_one_write", n_wr_acks, wr_base + 1);
            mem_ack = 1'b1;
            mem_din = 32'h99;
            #1;
            chk("t5_din", core_din, 32'h99);
            chk("t5_stall_drop", core_stall, 1'b0);
            $display("[TB] load addr=0x40 data=0x%0h", core_din);
            tick();
            mem_ack = 1'b0; core_ren = 1'b0; mem_din = '0;
            serve_write(32'h54, 32'h8, 1);
            #1;
            chk("t5_empty", buf_empty, 1'b1);
        end
`endif

        store(32'h60, 32'h61);
        store(32'h64, 32'h62);
        store(32'h68, 32'h63);
        wait_req("t6_req");
        chk("t6_we", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_req_drop", mem_req, 1'b0);
        chk("t6_empty", buf_empty, 1'b1);
        chk("t6_addr_clr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (mem_req !== 1'b0) begin
                n_fail++;
                $error("FAIL t6_no_req: cycle %0d observed %0b", i, mem_req);
            end
        end
        chk("t6_still_empty", buf_empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
